// File: rtl/toaplan_eeprom_pkg.sv
// Shared types and constants for the 93C46 serial EEPROM model.
// Holds the command-decoder state encoding and the 93C46 opcode set.
package toaplan_eeprom_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 6;
    localparam int WORDS  = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ADDR,
        ST_DATA_IN,
        ST_READ_OUT,
        ST_WAIT_CS,
        ST_BUSY
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b11;
    localparam logic [1:0] OP_EXT   = 2'b00;

    // Extended commands are selected by the top two address bits.
    localparam logic [1:0] EXT_EWEN = 2'b11;
    localparam logic [1:0] EXT_EWDS = 2'b00;
    localparam logic [1:0] EXT_ERAL = 2'b10;
    localparam logic [1:0] EXT_WRAL = 2'b01;

endpackage

// File: rtl/toaplan_eeprom_sync.sv
// Brings the asynchronous serial link into the CLK domain and flags
// each rising edge of the serial clock with a one-cycle pulse.
module toaplan_eeprom_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic scs,
    input  logic sdi,
    output logic sclk_rise,
    output logic scs_s,
    output logic sdi_s
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] scs_q;
    logic [SYNC_STAGES-1:0] sdi_q;
    logic                   sclk_d;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            scs_q  <= '0;
            sdi_q  <= '0;
            sclk_d <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            scs_q  <= {scs_q[SYNC_STAGES-2:0], scs};
            sdi_q  <= {sdi_q[SYNC_STAGES-2:0], sdi};
            sclk_d <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
    assign scs_s     = scs_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_q[SYNC_STAGES-1];

endmodule

// File: rtl/toaplan_eeprom_93c46.sv
// 93C46 (64 x 16) serial EEPROM responder with a host port for loading
// and saving the NVRAM image.
import toaplan_eeprom_pkg::*;

module toaplan_eeprom_93c46 #(
    parameter int BUSY_CYCLES = 4800,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        EEPROM_SCLK,
    input  logic        EEPROM_SCS,
    input  logic        EEPROM_SDI,
    output logic        EEPROM_SDO,
    input  logic [5:0]  HOST_ADDR,
    input  logic [15:0] HOST_DIN,
    input  logic        HOST_WE,
    output logic [15:0] HOST_DOUT,
    output logic        DIRTY,
    input  logic        HOST_CLR_DIRTY
);

    localparam int CNT_W = $clog2(BUSY_CYCLES + 1);

    state_t              state;
    logic [1:0]          opcode;
    logic [ADDR_W-1:0]   addr;
    logic [WORD_W-1:0]   data_sr;
    logic [4:0]          bit_cnt;
    logic                wen;
    logic                armed;
    logic                full_op;
    logic                dirty;
    logic                sdo;
    logic [CNT_W-1:0]    busy_cnt;
    logic [WORD_W-1:0]   mem [WORDS];

    logic                sclk_rise;
    logic                scs_s;
    logic                sdi_s;
    logic [ADDR_W-1:0]   addr_next;
    logic [ADDR_W-1:0]   addr_inc;
    logic [WORD_W-1:0]   next_word;
    logic                commit;
    logic                ser_we;
    logic [ADDR_W-1:0]   ser_addr;

    toaplan_eeprom_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .sclk      (EEPROM_SCLK),
        .scs       (EEPROM_SCS),
        .sdi       (EEPROM_SDI),
        .sclk_rise (sclk_rise),
        .scs_s     (scs_s),
        .sdi_s     (sdi_s)
    );

    assign addr_next = {addr[ADDR_W-2:0], sdi_s};
    assign addr_inc  = addr + 1'b1;
    assign next_word = mem[addr_inc];
    assign commit    = (state == ST_WAIT_CS) && !scs_s && armed && wen;

    // Single words land on the commit edge; full-array ops sweep one word per BUSY cycle.
    always_comb begin
        // NOTE: defaults first so no path leaves these undriven (no latch).
        ser_we   = 1'b0;
        ser_addr = addr;
        if (commit && !full_op) begin
            ser_we = 1'b1;
        end else if (state == ST_BUSY && full_op && busy_cnt < CNT_W'(WORDS)) begin
            ser_we   = 1'b1;
            ser_addr = busy_cnt[ADDR_W-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            opcode   <= '0;
            addr     <= '0;
            data_sr  <= '0;
            bit_cnt  <= '0;
            wen      <= 1'b0;
            armed    <= 1'b0;
            full_op  <= 1'b0;
            busy_cnt <= '0;
            sdo      <= 1'b1;
            dirty    <= 1'b0;
        end else begin
            if (commit) dirty <= 1'b1;
            else if (HOST_CLR_DIRTY) dirty <= 1'b0;

            case (state)
                ST_BUSY: begin
                    sdo <= !scs_s;
                    if (busy_cnt == CNT_W'(BUSY_CYCLES - 1)) begin
                        state    <= ST_IDLE;
                        busy_cnt <= '0;
                        full_op  <= 1'b0;
                        sdo      <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                ST_WAIT_CS: begin
                    if (!scs_s) begin
                        state    <= commit ? ST_BUSY : ST_IDLE;
                        full_op  <= commit ? full_op : 1'b0;
                        armed    <= 1'b0;
                        busy_cnt <= '0;
                        sdo      <= 1'b1;
                    end
                end
                default: begin
                    if (!scs_s) begin
                        state   <= ST_IDLE;
                        opcode  <= '0;
                        addr    <= '0;
                        data_sr <= '0;
                        bit_cnt <= '0;
                        armed   <= 1'b0;
                        full_op <= 1'b0;
                        sdo     <= 1'b1;
                    end else if (sclk_rise) begin
                        case (state)
                            ST_IDLE: begin
                                sdo <= 1'b1;
                                if (sdi_s) begin
                                    state   <= ST_OPCODE;
                                    bit_cnt <= '0;
                                end
                            end
                            ST_OPCODE: begin
                                opcode <= {opcode[0], sdi_s};
                                if (bit_cnt == 5'd1) begin
                                    state   <= ST_ADDR;
                                    bit_cnt <= '0;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            ST_ADDR: begin
                                addr <= addr_next;
                                if (bit_cnt == 5'd5) begin
                                    bit_cnt <= '0;
                                    case (opcode)
                                        OP_READ: begin
                                            state   <= ST_READ_OUT;
                                            sdo     <= 1'b0;
                                            data_sr <= mem[addr_next];
                                        end
                                        OP_WRITE: state <= ST_DATA_IN;
                                        OP_ERASE: begin
                                            state   <= ST_WAIT_CS;
                                            data_sr <= '1;
                                            armed   <= 1'b1;
                                        end
                                        default: begin
                                            case (addr_next[ADDR_W-1:ADDR_W-2])
                                                EXT_WRAL: begin
                                                    state   <= ST_DATA_IN;
                                                    full_op <= 1'b1;
                                                end
                                                EXT_ERAL: begin
                                                    state   <= ST_WAIT_CS;
                                                    data_sr <= '1;
                                                    armed   <= 1'b1;
                                                    full_op <= 1'b1;
                                                end
                                                EXT_EWEN: begin
                                                    state <= ST_WAIT_CS;
                                                    wen   <= 1'b1;
                                                end
                                                default: begin
                                                    state <= ST_WAIT_CS;
                                                    wen   <= 1'b0;
                                                end
                                            endcase
                                        end
                                    endcase
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            ST_DATA_IN: begin
                                data_sr <= {data_sr[WORD_W-2:0], sdi_s};
                                if (bit_cnt == 5'd15) begin
                                    state <= ST_WAIT_CS;
                                    armed <= 1'b1;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            ST_READ_OUT: begin
                                // A fully shifted word rolls over into the next address.
                                if (bit_cnt == 5'd16) begin
                                    addr    <= addr_inc;
                                    sdo     <= next_word[WORD_W-1];
                                    data_sr <= {next_word[WORD_W-2:0], 1'b0};
                                    bit_cnt <= 5'd1;
                                end else begin
                                    sdo     <= data_sr[WORD_W-1];
                                    data_sr <= {data_sr[WORD_W-2:0], 1'b0};
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // NOTE: storage has no reset so the NVRAM image survives RESET_N.
    always_ff @(posedge CLK) begin
        if (HOST_WE) mem[HOST_ADDR] <= HOST_DIN;
        if (ser_we)  mem[ser_addr]  <= data_sr;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) HOST_DOUT <= '0;
        else          HOST_DOUT <= mem[HOST_ADDR];
    end

    assign EEPROM_SDO = sdo;
    assign DIRTY      = dirty;

endmodule

// File: tb/tb_toaplan_eeprom_93c46.sv
// Directed and randomized serial/host traffic against an array-based
// model of the 93C46 contents, write-enable latch and dirty flag.
module tb_toaplan_eeprom_93c46;

    localparam int BUSY = 500;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk;
    logic        scs;
    logic        sdi;
    logic        sdo;
    logic [5:0]  haddr;
    logic [15:0] hdin;
    logic        hwe;
    logic [15:0] hdout;
    logic        dirty;
    logic        hclr;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] model [64];
    logic        model_dirty;

    toaplan_eeprom_93c46 #(.BUSY_CYCLES(BUSY), .SYNC_STAGES(2)) dut (
        .CLK            (clk),
        .RESET_N        (rst_n),
        .EEPROM_SCLK    (sclk),
        .EEPROM_SCS     (scs),
        .EEPROM_SDI     (sdi),
        .EEPROM_SDO     (sdo),
        .HOST_ADDR      (haddr),
        .HOST_DIN       (hdin),
        .HOST_WE        (hwe),
        .HOST_DOUT      (hdout),
        .DIRTY          (dirty),
        .HOST_CLR_DIRTY (hclr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sclk_bit(input logic b);
        @(negedge clk); sdi = b;
        repeat (2) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cs_on();
        @(negedge clk); scs = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic cs_off();
        @(negedge clk); scs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [5:0] a);
        logic [7:0] bits;
        bits = {op, a};
        sclk_bit(1'b1);
        for (int i = 7; i >= 0; i--) sclk_bit(bits[i]);
    endtask

    task automatic send_word(input logic [15:0] d, input int nbits);
        for (int i = 15; i > 15 - nbits; i--) sclk_bit(d[i]);
    endtask

    task automatic host_write(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk); haddr = a; hdin = d; hwe = 1'b1;
        @(negedge clk); hwe = 1'b0;
        model[a] = d;
    endtask

    task automatic host_check(input logic [5:0] a, input string tag);
        @(negedge clk); haddr = a;
        @(negedge clk);
        check($sformatf("%s host[%0d]", tag, a), hdout, model[a]);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 64; i++) host_check(6'(i), tag);
    endtask

    task automatic clear_dirty();
        @(negedge clk); hclr = 1'b1;
        @(negedge clk); hclr = 1'b0;
        model_dirty = 1'b0;
    endtask

    // Drop SCS to commit, raise it to poll ready/busy, then drop it again.
    task automatic commit(input bit busy_exp, input string tag);
        int n;
        @(negedge clk); scs = 1'b0; n = 0;
        repeat (4) begin @(negedge clk); n++; end
        scs = 1'b1;
        repeat (4) begin @(negedge clk); n++; end
        check({tag, " status"}, {15'd0, sdo}, busy_exp ? 16'd0 : 16'd1);
        while (sdo === 1'b0 && n < BUSY + 20) begin @(negedge clk); n++; end
        if (busy_exp) begin
            vectors++;
            assert (n >= BUSY && n <= BUSY + 6) else begin
                miscompares++;
                $error("FAIL %s busy length: observed %0d cycles expected %0d..%0d", tag, n, BUSY, BUSY + 6);
            end
        end
        check({tag, " ready"}, {15'd0, sdo}, 16'd1);
        cs_off();
    endtask

    task automatic serial_read(input logic [5:0] a, input int words, input string tag);
        logic [15:0] w;
        logic [5:0]  ai;
        cs_on();
        send_cmd(2'b10, a);
        check({tag, " dummy"}, {15'd0, sdo}, 16'd0);
        for (int k = 0; k < words; k++) begin
            ai = a + 6'(k);
            w  = model[ai];
            for (int b = 15; b >= 0; b--) begin
                sclk_bit(1'b0);
                check($sformatf("%s a%0d b%0d", tag, ai, b), {15'd0, sdo}, {15'd0, w[b]});
            end
        end
        cs_off();
        check({tag, " idle sdo"}, {15'd0, sdo}, 16'd1);
    endtask

    task automatic simple_cmd(input logic [5:0] a);
        cs_on(); send_cmd(2'b00, a); cs_off();
    endtask

    initial begin
        logic [15:0] d;
        logic [5:0]  a;

        rst_n = 1'b0; scs = 1'b0; sclk = 1'b0; sdi = 1'b0;
        haddr = '0; hdin = '0; hwe = 1'b0; hclr = 1'b0;
        model_dirty = 1'b0;
        repeat (3) @(negedge clk);
        check("reset sdo", {15'd0, sdo}, 16'd1);
        check("reset dirty", {15'd0, dirty}, 16'd0);
        check("reset hdout", hdout, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 64; i++) host_write(6'(i), 16'($urandom));
        check("host write no dirty", {15'd0, dirty}, 16'd0);
        cs_on();
        check("ready while idle", {15'd0, sdo}, 16'd1);
        cs_off();

        // EWEN then WRITE 5 <= 1234
        simple_cmd(6'b110000);
        cs_on(); send_cmd(2'b01, 6'd5); send_word(16'h1234, 16);
        commit(1'b1, "write5");
        model[5] = 16'h1234; model_dirty = 1'b1;
        host_check(6'd5, "write5");
        check("write5 dirty", {15'd0, dirty}, {15'd0, model_dirty});
        clear_dirty();
        check("dirty cleared", {15'd0, dirty}, 16'd0);

        // EWDS blocks WRITE 6
        simple_cmd(6'b000000);
        cs_on(); send_cmd(2'b01, 6'd6); send_word(16'hBEEF, 16);
        commit(1'b0, "ewds write6");
        host_check(6'd6, "ewds write6");
        check("ewds dirty", {15'd0, dirty}, 16'd0);

        // Sequential read across the 63 -> 0 wrap
        simple_cmd(6'b110000);
        host_write(6'd63, 16'hA5A5);
        host_write(6'd0, 16'h0F0F);
        serial_read(6'd63, 2, "wrap read");

        // ERAL, then WRAL 0000
        cs_on(); send_cmd(2'b00, 6'b100000);
        commit(1'b1, "eral");
        for (int i = 0; i < 64; i++) model[i] = 16'hFFFF;
        model_dirty = 1'b1;
        check("eral dirty", {15'd0, dirty}, 16'd1);
        check_all("eral");
        cs_on(); send_cmd(2'b00, 6'b010000); send_word(16'h0000, 16);
        commit(1'b1, "wral");
        for (int i = 0; i < 64; i++) model[i] = 16'h0000;
        check_all("wral");

        // Randomized WRITE/READ and ERASE
        for (int r = 0; r < 5; r++) begin
            a = 6'($urandom_range(0, 63));
            d = 16'($urandom);
            cs_on(); send_cmd(2'b01, a); send_word(d, 16);
            commit(1'b1, $sformatf("rnd write %0d", r));
            model[a] = d;
            serial_read(a, 1 + (r % 2), $sformatf("rnd read %0d", r));
        end
        a = 6'($urandom_range(0, 63));
        cs_on(); send_cmd(2'b11, a);
        commit(1'b1, "erase");
        model[a] = 16'hFFFF;
        host_check(a, "erase");

        // WRITE 9 aborted after 10 data bits
        host_write(6'd9, 16'h5A3C);
        cs_on(); send_cmd(2'b01, 6'd9); send_word(16'hC001, 10);
        cs_off();
        check("abort sdo", {15'd0, sdo}, 16'd1);
        host_check(6'd9, "abort");
        serial_read(6'd9, 1, "after abort");

        // Reset in the middle of a WRAL sweep
        clear_dirty();
        d = 16'($urandom) | 16'h0001;
        cs_on(); send_cmd(2'b00, 6'b010000); send_word(d, 16);
        @(negedge clk); scs = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset sdo", {15'd0, sdo}, 16'd1);
        check("midreset dirty", {15'd0, dirty}, 16'd0);
        for (int i = 0; i < 16; i++) model[i] = d;
        for (int i = 0; i < 16; i++) host_check(6'(i), "midreset new");
        for (int i = 48; i < 64; i++) host_check(6'(i), "midreset old");
        for (int i = 16; i < 48; i++) host_write(6'(i), 16'($urandom));
        a = 6'd7;
        cs_on(); send_cmd(2'b01, a); send_word(~model[a], 16);
        commit(1'b0, "wen cleared");
        host_check(a, "wen cleared");
        check("wen cleared dirty", {15'd0, dirty}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
